alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 192 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: three-stage (RD / EX / WB) integer pipeline with a register
// file, an ALU, a word-addressed data memory and full forwarding, so that
// dependent instructions can issue back to back without stalls.
module alu_pipe #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic                     RegWrite,
  input  logic                     MemWrite,
  input  logic                     ALUsrc,
  input  logic                     Resultsrc,
  input  logic [2:0]               ALUctrl,
  input  logic [DATA_WIDTH-1:0]    immOp,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     valid_out,
  output logic [DATA_WIDTH-1:0]    ALUout,
  output logic                     EQ,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREGS = 2 ** ADDRESS_WIDTH;
  localparam int MDEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  // Architectural state
  logic [DATA_WIDTH-1:0]    r_regs [0:NREGS-1];
  logic [DATA_WIDTH-1:0]    r_mem  [0:MDEPTH-1];

  // RD/EX pipeline register
  logic                     r_ex_vld;
  logic                     r_ex_regwrite;
  logic                     r_ex_memwrite;
  logic                     r_ex_alusrc;
  logic                     r_ex_resultsrc;
  logic [2:0]               r_ex_aluctrl;
  logic [DATA_WIDTH-1:0]    r_ex_imm;
  logic [ADDRESS_WIDTH-1:0] r_ex_rs1;
  logic [ADDRESS_WIDTH-1:0] r_ex_rs2;
  logic [ADDRESS_WIDTH-1:0] r_ex_rd;
  logic [DATA_WIDTH-1:0]    r_ex_rs1v;
  logic [DATA_WIDTH-1:0]    r_ex_rs2v;

  // EX/WB pipeline register
  logic                     r_wb_vld;
  logic                     r_wb_regwrite;
  logic                     r_wb_resultsrc;
  logic [ADDRESS_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]    r_wb_alu;
  logic                     r_wb_eq;
  logic [DATA_WIDTH-1:0]    r_wb_mrd;

  // Combinational nets
  logic                      w_wb_we;
  logic [DATA_WIDTH-1:0]     w_wb_wdata;
  logic [DATA_WIDTH-1:0]     w_rs1_val;
  logic [DATA_WIDTH-1:0]     w_rs2_val;
  logic [DATA_WIDTH-1:0]     w_op1;
  logic [DATA_WIDTH-1:0]     w_fwd2;
  logic [DATA_WIDTH-1:0]     w_op2;
  logic signed [DATA_WIDTH-1:0] w_op1_s;
  logic signed [DATA_WIDTH-1:0] w_op2_s;
  logic [DATA_WIDTH-1:0]     w_alu;
  logic [MEM_ADDR_WIDTH-1:0] w_maddr;
  logic                      w_unused_addr;

  // WB write port: bubbles and x0 never write and never forward
  assign w_wb_we    = r_wb_vld && r_wb_regwrite && (r_wb_rd != '0);
  assign w_wb_wdata = r_wb_resultsrc ? r_wb_mrd : r_wb_alu;

  // RD stage: register read with same-cycle bypass of the WB write
  assign w_rs1_val = (rs1 == '0) ? '0 :
                     (w_wb_we && (r_wb_rd == rs1)) ? w_wb_wdata : r_regs[rs1];
  assign w_rs2_val = (rs2 == '0) ? '0 :
                     (w_wb_we && (r_wb_rd == rs2)) ? w_wb_wdata : r_regs[rs2];

  // EX stage: forward the instruction currently in WB
  assign w_op1  = (w_wb_we && (r_wb_rd == r_ex_rs1)) ? w_wb_wdata : r_ex_rs1v;
  assign w_fwd2 = (w_wb_we && (r_wb_rd == r_ex_rs2)) ? w_wb_wdata : r_ex_rs2v;
  assign w_op2  = r_ex_alusrc ? r_ex_imm : w_fwd2;
  assign w_op1_s = w_op1;
  assign w_op2_s = w_op2;

  // ALU operation select; arithmetic wraps, shifts use the low SHW bits
  always_comb begin
    w_alu = '0;
    case (r_ex_aluctrl)
      OP_ADD:  w_alu = w_op1 + w_op2;
      OP_SUB:  w_alu = w_op1 - w_op2;
      OP_AND:  w_alu = w_op1 & w_op2;
      OP_OR:   w_alu = w_op1 | w_op2;
      OP_XOR:  w_alu = w_op1 ^ w_op2;
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_op1_s < w_op2_s)};
      OP_SLL:  w_alu = w_op1 << w_op2[SHW-1:0];
      OP_SRL:  w_alu = w_op1 >> w_op2[SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  // Word address from the ALU result; byte offset and high bits are dropped
  assign w_maddr       = w_alu[MEM_ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{w_alu[DATA_WIDTH-1:MEM_ADDR_WIDTH+2], w_alu[1:0]};

  // RD -> EX pipeline register capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_vld       <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_alusrc    <= 1'b0;
      r_ex_resultsrc <= 1'b0;
      r_ex_aluctrl   <= '0;
      r_ex_imm       <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_rs1v      <= '0;
      r_ex_rs2v      <= '0;
    end else begin
      r_ex_vld       <= valid_in;
      r_ex_regwrite  <= RegWrite;
      r_ex_memwrite  <= MemWrite;
      r_ex_alusrc    <= ALUsrc;
      r_ex_resultsrc <= Resultsrc;
      r_ex_aluctrl   <= ALUctrl;
      r_ex_imm       <= immOp;
      r_ex_rs1       <= rs1;
      r_ex_rs2       <= rs2;
      r_ex_rd        <= rd;
      r_ex_rs1v      <= w_rs1_val;
      r_ex_rs2v      <= w_rs2_val;
    end
  end

  // EX -> WB pipeline register capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_vld       <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_resultsrc <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_alu       <= '0;
      r_wb_eq        <= 1'b0;
    end else begin
      r_wb_vld       <= r_ex_vld;
      r_wb_regwrite  <= r_ex_regwrite;
      r_wb_resultsrc <= r_ex_resultsrc;
      r_wb_rd        <= r_ex_rd;
      r_wb_alu       <= w_alu;
      r_wb_eq        <= (w_op1 == w_op2);
    end
  end

  // Data memory: store leaving EX, synchronous read landing in WB (not reset)
  always_ff @(posedge clk) begin
    if (r_ex_vld && r_ex_memwrite) begin
      r_mem[w_maddr] <= w_fwd2;
    end
    r_wb_mrd <= r_mem[w_maddr];
  end

  // Register file write from WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[r_wb_rd] <= w_wb_wdata;
    end
  end

  assign valid_out = r_wb_vld;
  assign ALUout    = r_wb_alu;
  assign EQ        = r_wb_eq;
  assign a0        = r_regs[10];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: linear instruction sequences with
// hand-computed results, checked by immediate assertions.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        RegWrite;
  logic        MemWrite;
  logic        ALUsrc;
  logic        Resultsrc;
  logic [2:0]  ALUctrl;
  logic [31:0] immOp;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        valid_out;
  logic [31:0] ALUout;
  logic        EQ;
  logic [31:0] a0;

  int n_assert;
  int n_fail;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

  alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUsrc(ALUsrc), .Resultsrc(Resultsrc),
    .ALUctrl(ALUctrl), .immOp(immOp), .rs1(rs1), .rs2(rs2), .rd(rd),
    .valid_out(valid_out), .ALUout(ALUout), .EQ(EQ), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic mw, input logic asrc,
                       input logic rsrc, input logic [2:0] ctrl,
                       input logic [31:0] imm, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d);
    valid_in = 1'b1; RegWrite = rw; MemWrite = mw; ALUsrc = asrc;
    Resultsrc = rsrc; ALUctrl = ctrl; immOp = imm; rs1 = s1; rs2 = s2; rd = d;
    step();
  endtask

  task automatic bubble();
    valid_in = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    step();
  endtask

  logic [2:0]  op_ctrl [0:8];
  logic [31:0] op_imm  [0:8];
  logic [31:0] op_exp  [0:8];

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; valid_in = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    ALUsrc = 1'b0; Resultsrc = 1'b0; ALUctrl = 3'b000; immOp = '0;
    rs1 = '0; rs2 = '0; rd = '0;

    op_ctrl = '{ADD, SUB, AND_, OR_, XOR_, SLT, SLL, SRL, SLL};
    op_imm  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd33};
    op_exp  = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE,
                32'h1, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFE};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_aluout", ALUout, 32'd0);
    chk("rst_eq", {31'b0, EQ}, 32'd0);
    chk("rst_a0", a0, 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5 latency
    issue(1, 0, 1, 0, ADD, 32'd5, 0, 0, 1);
    chk("addi_not_yet_valid", {31'b0, valid_out}, 32'd0);
    bubble();
    chk("addi_valid_out", {31'b0, valid_out}, 32'd1);
    chk("addi_aluout", ALUout, 32'd5);
    bubble();
    chk("addi_x1", dut.r_regs[1], 32'd5);
    chk("addi_bubble_out", {31'b0, valid_out}, 32'd0);

    // Back-to-back dependents
    issue(1, 0, 1, 0, ADD, 32'd5, 0, 0, 1);
    issue(1, 0, 0, 0, ADD, 32'd0, 1, 1, 2);
    chk("dep_alu0", ALUout, 32'd5);
    issue(1, 0, 0, 0, SUB, 32'd0, 2, 1, 3);
    chk("dep_alu1", ALUout, 32'd10);
    chk("dep_valid1", {31'b0, valid_out}, 32'd1);
    bubble();
    chk("dep_alu2", ALUout, 32'd5);
    chk("dep_valid2", {31'b0, valid_out}, 32'd1);
    bubble();
    chk("dep_x2", dut.r_regs[2], 32'd10);
    chk("dep_x3", dut.r_regs[3], 32'd5);

    // Store / load / dependent add
    issue(1, 0, 1, 0, ADD, 32'h1234, 0, 0, 1);
    issue(0, 1, 1, 0, ADD, 32'd8, 0, 1, 0);
    chk("st_addi_alu", ALUout, 32'h1234);
    issue(1, 0, 1, 1, ADD, 32'd8, 0, 0, 4);
    chk("st_sw_addr", ALUout, 32'd8);
    issue(1, 0, 0, 0, ADD, 32'd0, 4, 4, 5);
    chk("st_lw_addr", ALUout, 32'd8);
    bubble();
    chk("st_add_alu", ALUout, 32'h2468);
    bubble();
    chk("st_x4", dut.r_regs[4], 32'h1234);
    chk("st_x5", dut.r_regs[5], 32'h2468);

    // a0 tracks register 10
    issue(1, 0, 1, 0, ADD, 32'h55, 0, 0, 10);
    bubble();
    chk("a0_before_write", a0, 32'd0);
    bubble();
    chk("a0_after_write", a0, 32'h55);

    // x0 protection
    issue(1, 0, 1, 0, ADD, 32'd7, 0, 0, 0);
    issue(1, 0, 0, 0, ADD, 32'd0, 0, 0, 6);
    chk("x0_alu7", ALUout, 32'd7);
    bubble();
    chk("x0_alu0", ALUout, 32'd0);
    chk("x0_eq", {31'b0, EQ}, 32'd1);
    bubble();
    chk("x0_x6", dut.r_regs[6], 32'd0);
    chk("x0_x0", dut.r_regs[0], 32'd0);

    // ALU operations on 0xFFFFFFFF and flags
    issue(1, 0, 1, 0, ADD, 32'hFFFFFFFF, 0, 0, 8);
    for (int i = 0; i < 9; i++) begin
      issue(1, 0, 1, 0, op_ctrl[i], op_imm[i], 8, 0, 9);
      if (i == 0) chk("ops_x8", ALUout, 32'hFFFFFFFF);
      else        chk($sformatf("ops_%0d", i - 1), ALUout, op_exp[i-1]);
      chk($sformatf("ops_eq_%0d", i), {31'b0, EQ}, 32'd0);
    end
    issue(1, 0, 0, 0, ADD, 32'd0, 8, 8, 9);
    chk("ops_8", ALUout, op_exp[8]);
    bubble();
    chk("eq_equal_alu", ALUout, 32'hFFFFFFFE);
    chk("eq_equal_flag", {31'b0, EQ}, 32'd1);
    bubble();

    // Reset with two x7 writers in flight
    issue(1, 0, 1, 0, ADD, 32'd3, 0, 0, 7);
    issue(1, 0, 1, 0, ADD, 32'd4, 0, 0, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("mrst_x7", dut.r_regs[7], 32'd0);
    chk("mrst_a0", a0, 32'd0);
    chk("mrst_aluout", ALUout, 32'd0);
    valid_in = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    step();
    rst_n = 1'b1;
    bubble();
    bubble();
    chk("mrst_x7_after", dut.r_regs[7], 32'd0);
    chk("mrst_valid_after", {31'b0, valid_out}, 32'd0);

    // Reset discards an in-flight store
    issue(1, 0, 1, 0, ADD, 32'h1111, 0, 0, 8);
    issue(0, 1, 1, 0, ADD, 32'd12, 0, 8, 0);
    issue(1, 0, 1, 0, ADD, 32'h2222, 0, 0, 8);
    bubble();
    bubble();
    chk("mst_x8", dut.r_regs[8], 32'h2222);
    issue(0, 1, 1, 0, ADD, 32'd12, 0, 8, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mst_valid_out", {31'b0, valid_out}, 32'd0);
    valid_in = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mst_x8_cleared", dut.r_regs[8], 32'd0);
    issue(1, 0, 1, 1, ADD, 32'd12, 0, 0, 11);
    bubble();
    bubble();
    chk("mst_mem_kept", dut.r_regs[11], 32'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
